// File: rtl/memshare_delta_skid_ctrl.sv
// memshare_delta_skid_ctrl: round-sequenced per-channel skid flag and shift delta tracker for SCU memShare
module memshare_delta_skid_ctrl #(
    parameter int   CH_NUM       = 4,
    parameter int   DELTA_W      = 3,
    parameter int   ITER_W       = 4,
    parameter logic RST_POLARITY = 1'b0
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [ITER_W-1:0]         iter_num_i,
    input  logic                      abort_i,
    input  logic                      rnd_valid_i,
    input  logic [CH_NUM-1:0]         isGtr_i,
    input  logic [CH_NUM*DELTA_W-1:0] delta_i,
    output logic [CH_NUM-1:0]         skid_o,
    output logic [CH_NUM*DELTA_W-1:0] delta_o,
    output logic [ITER_W-1:0]         round_o,
    output logic                      busy_o,
    output logic                      done_o
);
    typedef enum logic [1:0] {IDLE, READ_COL_ADDR, SHIFT_GEN, DONE} state_t;

    localparam logic [CH_NUM-1:0] SKID_INIT = {CH_NUM{RST_POLARITY}};

    state_t                    state;
    logic [ITER_W-1:0]         iter_q;
    logic [ITER_W-1:0]         round_nx;
    logic [CH_NUM*DELTA_W-1:0] delta_nx;

    assign round_nx = round_o + 1'b1;

    // channels flagged by isGtr capture their candidate delta, the rest hold
    always_comb begin
        delta_nx = delta_o;
        for (int c = 0; c < CH_NUM; c++)
            if (isGtr_i[c]) delta_nx[c*DELTA_W +: DELTA_W] = delta_i[c*DELTA_W +: DELTA_W];
    end

    // sequencer: abort wins over everything outside IDLE, outputs are registered
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            iter_q  <= '0;
            skid_o  <= SKID_INIT;
            delta_o <= '0;
            round_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else if (state != IDLE && abort_i) begin
            state   <= IDLE;
            skid_o  <= SKID_INIT;
            delta_o <= '0;
            round_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        iter_q <= iter_num_i;
                        state  <= READ_COL_ADDR;
                        busy_o <= 1'b1;
                    end
                end
                READ_COL_ADDR: begin
                    skid_o  <= SKID_INIT;
                    delta_o <= '0;
                    round_o <= '0;
                    state   <= (iter_q == '0) ? DONE : SHIFT_GEN;
                    busy_o  <= (iter_q != '0);
                    done_o  <= (iter_q == '0);
                end
                SHIFT_GEN: begin
                    if (rnd_valid_i) begin
                        skid_o  <= skid_o ^ isGtr_i;
                        delta_o <= delta_nx;
                        round_o <= round_nx;
                        if (round_nx == iter_q) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    skid_o <= SKID_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memshare_delta_skid_ctrl.sv
// tb_memshare_delta_skid_ctrl: scoreboard bench for both skid reset polarities
module tb_memshare_delta_skid_ctrl;
    logic        sys_clk;
    logic        rst;
    logic        start_i;
    logic [3:0]  iter_num_i;
    logic        abort_i;
    logic        rnd_valid_i;
    logic [3:0]  isGtr_i;
    logic [11:0] delta_i;
    logic [3:0]  skid0, skid1, rnd0, rnd1;
    logic [11:0] del0, del1;
    logic        busy0, busy1, done0, done1;

    typedef struct {
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [11:0] d;
        logic [3:0]  r;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  g_tab[16];
    logic [11:0] d_tab[16];
    int          n_cmp = 0;
    int          n_err = 0;

    memshare_delta_skid_ctrl dut0 (
        .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .iter_num_i(iter_num_i),
        .abort_i(abort_i), .rnd_valid_i(rnd_valid_i), .isGtr_i(isGtr_i), .delta_i(delta_i),
        .skid_o(skid0), .delta_o(del0), .round_o(rnd0), .busy_o(busy0), .done_o(done0)
    );

    memshare_delta_skid_ctrl #(.RST_POLARITY(1'b1)) dut1 (
        .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .iter_num_i(iter_num_i),
        .abort_i(abort_i), .rnd_valid_i(rnd_valid_i), .isGtr_i(isGtr_i), .delta_i(delta_i),
        .skid_o(skid1), .delta_o(del1), .round_o(rnd1), .busy_o(busy1), .done_o(done1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // every done pulse consumes one expected final result
    always @(negedge sys_clk) begin
        if (done0) begin
            if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_skid0", skid0, e.s0);
                chk("sb_skid1", skid1, e.s1);
                chk("sb_delta", del0, e.d);
                chk("sb_delta_pol1", del1, e.d);
                chk("sb_round", rnd0, e.r);
                chk("sb_busy", busy0, 0);
                chk("sb_done_pol1", done1, 1);
            end
        end
    end

    task automatic run_op(input logic [3:0] n, input int gap);
        exp_t e;
        e.s0 = 4'h0;
        e.s1 = 4'hF;
        e.d  = '0;
        e.r  = n;
        for (int i = 0; i < n; i++) begin
            e.s0 ^= g_tab[i];
            e.s1 ^= g_tab[i];
            for (int c = 0; c < 4; c++)
                if (g_tab[i][c]) e.d[c*3 +: 3] = d_tab[i][c*3 +: 3];
        end
        sb.push_back(e);
        start_i = 1'b1;
        iter_num_i = n;
        tick;
        chk("busy_rca", busy0, 1);
        chk("skid1_rca", skid1, 4'hF);
        iter_num_i = ~n;
        tick;
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                start_i = 1'b1;
                iter_num_i = 4'd1;
                rnd_valid_i = 1'b0;
                isGtr_i = 4'hF;
                delta_i = 12'hFFF;
                tick;
                chk("gap_round_hold", rnd0, i);
                chk("gap_busy", busy0, 1);
            end
            start_i = 1'b0;
            rnd_valid_i = 1'b1;
            isGtr_i = g_tab[i];
            delta_i = d_tab[i];
            tick;
            chk("round_inc", rnd0, i + 1);
            if (i < n - 1) chk("done_early", done0, 0);
        end
        rnd_valid_i = 1'b0;
        chk("done_at", done0, 1);
        chk("busy_in_done", busy0, 0);
        start_i = 1'b1;
        iter_num_i = 4'd2;
        tick;
        start_i = 1'b0;
        chk("idle_skid0", skid0, 4'h0);
        chk("idle_skid1", skid1, 4'hF);
        chk("idle_delta_kept", del0, e.d);
        chk("idle_done_low", done0, 0);
        tick;
        chk("start_in_done_ignored", busy0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        iter_num_i = '0;
        abort_i = 1'b0;
        rnd_valid_i = 1'b0;
        isGtr_i = '0;
        delta_i = '0;
        repeat (2) tick;
        chk("rst_skid0", skid0, 4'h0);
        chk("rst_skid1", skid1, 4'hF);
        chk("rst_delta", del0, 0);
        chk("rst_round", rnd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        rst = 1'b0;
        tick;

        g_tab[0] = 4'b0011; d_tab[0] = {3'd7, 3'd3, 3'd5, 3'd1};
        g_tab[1] = 4'b0110; d_tab[1] = {3'd6, 3'd4, 3'd2, 3'd0};
        g_tab[2] = 4'b0000; d_tab[2] = 12'hFFF;
        run_op(4'd3, 0);
        chk("opA_ch1_delta", del0[5:3], 3'd2);

        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        chk("abort_idle_ignored", del0, {3'd0, 3'd4, 3'd2, 3'd1});

        g_tab[0] = 4'b1000; d_tab[0] = {3'd6, 3'd1, 3'd1, 3'd1};
        run_op(4'd1, 0);

        run_op(4'd0, 0);
        chk("iter0_delta", del0, 0);
        chk("iter0_round", rnd0, 0);

        for (int i = 0; i < 4; i++) begin
            g_tab[i] = 4'($urandom);
            d_tab[i] = 12'($urandom);
        end
        run_op(4'd4, 3);

        start_i = 1'b1;
        iter_num_i = 4'd3;
        tick;
        start_i = 1'b0;
        tick;
        abort_i = 1'b1;
        rnd_valid_i = 1'b1;
        isGtr_i = 4'hF;
        delta_i = 12'hFFF;
        tick;
        abort_i = 1'b0;
        rnd_valid_i = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_delta", del0, 0);
        chk("abort_round", rnd0, 0);
        chk("abort_skid0", skid0, 4'h0);
        chk("abort_skid1", skid1, 4'hF);
        tick;
        chk("abort_no_done", done0, 0);

        g_tab[0] = 4'b0011; d_tab[0] = 12'o7351;
        g_tab[1] = 4'b0110; d_tab[1] = 12'o6420;
        start_i = 1'b1;
        iter_num_i = 4'd3;
        tick;
        start_i = 1'b0;
        tick;
        for (int i = 0; i < 2; i++) begin
            rnd_valid_i = 1'b1;
            isGtr_i = g_tab[i];
            delta_i = d_tab[i];
            tick;
        end
        rnd_valid_i = 1'b0;
        chk("mid_round", rnd0, 2);
        chk("mid_skid0", skid0, 4'b0101);
        #3 rst = 1'b1;
        #1;
        chk("async_skid0", skid0, 4'h0);
        chk("async_skid1", skid1, 4'hF);
        chk("async_delta", del0, 0);
        chk("async_round", rnd0, 0);
        chk("async_busy", busy0, 0);
        #2 rst = 1'b0;
        tick;
        tick;
        chk("post_rst_idle", busy0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memshare_delta_skid_ctrl.md
Name: memshare_delta_skid_ctrl

Overview:
- Multi-channel, round-sequenced successor of the single-bit memShare delta reset generator.
- Owns the per-channel skid flag and captured shift delta for each shared-memory group across every SHIFT_GEN round of one SCU.memShare() operation.
- Has its own READ_COL_ADDR/SHIFT_GEN sequencer, round counter, abort and done signalling.
- Sits between the RFMU (isGtr, delta candidates) and the access request generator's shift stage.

Parameters:
- CH_NUM, 4: number of memShare channels/groups.
- DELTA_W, 3: width of one channel's shift delta.
- ITER_W, 4: width of the round counter and round-count input.
- RST_POLARITY, 1'b0: initial (NOSKID) value of every skid flag.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle request to begin a memShare operation; honoured only in IDLE.
- iter_num_i  in  ITER_W  number of SHIFT_GEN rounds; sampled with start_i.
- abort_i  in  1  cancels the operation; channel state returns to initial.
- rnd_valid_i  in  1  RFMU results valid for the current round.
- isGtr_i  in  CH_NUM  per-channel isGtr from the RFMU.
- delta_i  in  CH_NUM*DELTA_W  per-channel candidate delta; channel c occupies bits [c*DELTA_W +: DELTA_W].
- skid_o  out  CH_NUM  per-channel skid flag.
- delta_o  out  CH_NUM*DELTA_W  per-channel captured delta.
- round_o  out  ITER_W  number of completed rounds.
- busy_o  out  1  high in READ_COL_ADDR and SHIFT_GEN.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; skid_o all bits = RST_POLARITY.
  - delta_o=0, round_o=0, busy_o=0, done_o=0; latched iter_num=0.
- All outputs are registered.
- IDLE:
  - start_i=1 latches iter_num_i and moves to READ_COL_ADDR.
  - abort_i is ignored in IDLE.
  - skid_o is held at RST_POLARITY. delta_o retains the last completed result.
- READ_COL_ADDR (exactly 1 cycle):
  - Synchronously sets skid to RST_POLARITY, delta to 0 and round to 0.
  - Next state is SHIFT_GEN, or DONE if the latched iter_num==0.
- SHIFT_GEN:
  - On each cycle with rnd_valid_i=1, for every channel c:
    - skid[c] <= skid[c] ^ isGtr_i[c].
    - delta[c] <= delta_i[c] when isGtr_i[c]=1, else delta[c] is held.
    - round increments by 1.
  - Results are visible the following cycle.
  - rnd_valid_i=0 leaves all state held, with no timeout.
  - The valid round that brings round to iter_num moves the FSM to DONE.
- DONE (exactly 1 cycle):
  - done_o=1, busy_o=0.
  - skid_o and delta_o show the final values.
  - Next state is IDLE; on that transition skid is set to RST_POLARITY and delta is kept.
- Latency: start_i at cycle t gives busy_o=1 from t+1 and first valid round accepted at t+2. The minimum operation is t+1..t+N+1 busy and done_o at t+N+2.
- abort_i in READ_COL_ADDR, SHIFT_GEN or DONE:
  - Next state is IDLE; skid=RST_POLARITY, delta=0, round=0.
  - No done_o pulse. abort_i has priority over rnd_valid_i in the same cycle.
- start_i while not in IDLE is ignored, with no re-latch of iter_num.
- start_i in the same cycle that DONE→IDLE is ignored; it must be re-issued from IDLE.
- isGtr_i and delta_i are don't-care when rnd_valid_i=0 or outside SHIFT_GEN.
- round never wraps: iter_num ≤ 2^ITER_W−1, and the transition occurs at equality.
- skid_o never differs from RST_POLARITY outside the READ_COL_ADDR..DONE window, which prevents X propagation into the downstream delta FF.
- Channels are fully independent. Simultaneous toggles on all channels in one round are legal.

Test Plan:
- Reset mid-SHIFT_GEN (round_o=2, skid_o=4'b0101) with rst pulsed asynchronously between edges → all outputs return to their reset values immediately, without waiting for a clock edge; state=IDLE.
- CH_NUM=4, iter_num_i=3; rounds with isGtr_i=4'b0011, 4'b0110, 4'b0000; delta_i for ch1 = 5 then 2 → skid_o=4'b0101 and ch1 delta_o=2 during DONE; done_o=1 exactly at cycle start+1+3+1 when valid is continuous; skid_o=4'b0000 in the following IDLE cycle.
- RST_POLARITY=1, iter_num_i=1, isGtr_i=4'b1000 → skid_o=4'b0111 in DONE, 4'b1111 before and after the operation.
- iter_num_i=0 → READ_COL_ADDR then DONE; done_o pulses at start+2; round_o=0; delta_o=0.
- iter_num_i=4 with rnd_valid_i gaps of 3 idle cycles between rounds → state held across the gaps; round_o increments only on valid; done_o after the 4th valid.
- abort_i asserted together with rnd_valid_i at round 1 → no update applied; IDLE next cycle; delta_o=0; no done_o. A start_i during busy from an earlier operation is likewise ignored, with iter_num unchanged.
